pipelined_ripple_adder: RTL
===========================

// Module: pipelined_ripple_adder
// PURPOSE
//   Parametrised, pipelined add/subtract unit: WIDTH-bit ripple-carry adder split into
//   SEG_WIDTH-bit segments, one register stage per segment, carry passed stage to stage.
//   Valid/ready stream interface, one result per cycle, plus signed-overflow flag.
//   Next-generation datapath adder for WIDTH-wide arithmetic where a full-width ripple misses timing.
// PARAMETERS
//   WIDTH      16  operand/result width; must be an integer multiple of SEG_WIDTH
//   SEG_WIDTH   4  bits rippled per pipeline stage; NSEG = WIDTH/SEG_WIDTH = latency in cycles
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit accepts a beat this cycle
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: A+B+cin; 1: A-B-cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      add: carry-out; sub: 1 = no borrow (A >= B+cin, unsigned)
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all stage valid bits, out_valid, sum, cout, ovf -> 0;
//     in-flight beats discarded; in_ready=0 while rst=1. Mid-operation reset, same rule.
//   - Arithmetic: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin; {cout,sum} = a + b_eff + c0.
//   - Stage k (0..NSEG-1) adds segment k of a/b_eff with carry from stage k-1 (stage 0: c0);
//     registers its sum slice, carry-out, valid, and the not-yet-added operand slices.
//     Completed sum slices travel with the beat (skew-free at output).
//   - Last stage also registers carry into MSB for ovf.
//   - Latency: beat accepted at edge T appears on out_valid/sum after edge T+NSEG-1
//     (NSEG=1 -> visible the cycle after acceptance). Throughput 1 beat/cycle.
//   - Flow control: advance = out_ready | ~out_valid; in_ready = advance & ~rst.
//     Accept when in_valid & in_ready. advance=0: every stage holds (global stall, no bubble
//     collapse); sum/cout/ovf stable while out_valid & ~out_ready.
//   - Bubbles: advance=1 with no accept inserts valid=0 into stage 0; bubbles propagate.
//   - out_valid & out_ready & new beat completing same cycle: output replaced, no loss/dup.
//   - Wrap-around: sum truncated to WIDTH; carry/borrow reported only via cout.
//   - Illegal WIDTH % SEG_WIDTH != 0: elaboration-time error.
// STRUCTURE
//   - Shared package/header: NSEG computation, stage record layout (valid, carry, sum slice,
//     operand slices), parameter legality check.
//   - Sub-module rca_segment: combinational SEG_WIDTH-bit ripple of full adders;
//     outputs sum slice, carry-out, carry into its MSB. Instantiated NSEG times via generate.
//   - Top: operand conditioning (sub inversion), stage registers, flow-control logic.
// TESTING (WIDTH=16, SEG_WIDTH=4 unless noted; latency 4)
//   1 a=FFFF b=0001 cin=0 sub=0 -> 4 cycles later sum=0000 cout=1 ovf=0.
//   2 a=7FFF b=0001 cin=0 sub=0 -> sum=8000 cout=0 ovf=1; a=0007 b=0008 cin=1 -> 0010 cout=0.
//   3 sub=1: 0005-0003 cin=0 -> 0002 cout=1; 0003-0005 -> FFFE cout=0; 8000-0001 -> 7FFF ovf=1.
//   4 WIDTH=4 SEG_WIDTH=4: 0111+1000+cin1 -> sum=0000 cout=1, 1 cycle latency.
//   5 Stream 64 random beats, out_ready toggled randomly -> results in order, none lost or
//     duplicated, outputs stable during stall, scoreboard match.
//   6 Assert rst with 3 beats in flight -> next cycle out_valid=0, sum=0; post-reset beat
//     0001+0001 -> 0002 after 4 cycles, no stale beat emerges.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the segmented, pipelined ripple-carry add/subtract unit.
// Holds the stage-count math, the legality check and the per-stage control record.
package pipelined_ripple_adder_pkg;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefSegWidth = 4;

    // A zero segment width yields one stage so elaboration reaches the legality check.
    function automatic int unsigned calc_nseg(int unsigned width, int unsigned seg_width);
        return (seg_width == 0) ? 1 : width / seg_width;
    endfunction

    function automatic bit is_legal(int unsigned width, int unsigned seg_width);
        return (seg_width != 0) && (width >= seg_width) && (width % seg_width == 0);
    endfunction

    function automatic logic fa_carry(logic x, logic y, logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Control part of a stage record; the sum and operand slices sit beside it as
    // WIDTH-wide vectors in the top.
    typedef struct packed {
        logic valid;
        logic carry;
        logic cmsb;
    } stage_ctl_t;

endpackage

// File: rtl/pipelined_ripple_adder_rca_segment.sv
// Combinational SEG_WIDTH-bit ripple of full adders for one pipeline stage.
// Also exposes the carry into its MSB so the last stage can flag signed overflow.
module rca_segment
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int unsigned SEG_WIDTH = DefSegWidth
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 cout,
    output logic                 cmsb
);

    always_comb begin
        logic carry;
        carry = cin;
        cmsb  = cin;
        s     = '0;
        for (int i = 0; i < int'(SEG_WIDTH); i++) begin
            if (i == int'(SEG_WIDTH) - 1) begin
                cmsb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = fa_carry(a[i], b[i], carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: WIDTH-bit ripple split into NSEG registered segments with a
// valid/ready stream interface, a global stall and a signed-overflow flag.
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned SEG_WIDTH = DefSegWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSEG = calc_nseg(WIDTH, SEG_WIDTH);

    if (!is_legal(WIDTH, SEG_WIDTH)) begin : g_illegal_params
        $fatal(1, "pipelined_ripple_adder: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Registered stage records.
    stage_ctl_t       ctl_q [NSEG];
    logic [WIDTH-1:0] sum_q [NSEG];
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];

    // Inputs seen by each stage's adder, and the resulting next-state record.
    stage_ctl_t       ctl_d     [NSEG];
    logic [WIDTH-1:0] sum_d     [NSEG];
    logic [WIDTH-1:0] stage_a   [NSEG];
    logic [WIDTH-1:0] stage_b   [NSEG];
    logic [WIDTH-1:0] stage_sin [NSEG];
    logic             stage_cin [NSEG];
    logic             stage_vin [NSEG];

    logic [SEG_WIDTH-1:0] seg_sum  [NSEG];
    logic                 seg_cout [NSEG];
    logic                 seg_cmsb [NSEG];

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // Global stall: every stage moves together, bubbles are never squeezed out.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance & ~rst;

    for (genvar k = 0; k < int'(NSEG); k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_a[k]   = a;
            assign stage_b[k]   = b_eff;
            assign stage_sin[k] = '0;
            assign stage_cin[k] = c0;
            assign stage_vin[k] = in_valid & in_ready;
        end else begin : g_next
            assign stage_a[k]   = a_q[k-1];
            assign stage_b[k]   = b_q[k-1];
            assign stage_sin[k] = sum_q[k-1];
            assign stage_cin[k] = ctl_q[k-1].carry;
            assign stage_vin[k] = ctl_q[k-1].valid;
        end

        rca_segment #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .a    (stage_a[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .b    (stage_b[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .cin  (stage_cin[k]),
            .s    (seg_sum[k]),
            .cout (seg_cout[k]),
            .cmsb (seg_cmsb[k])
        );

        // Slices at and above k are still zero on entry, so OR merges the new slice in.
        assign sum_d[k] = stage_sin[k] | (WIDTH'(seg_sum[k]) << (k * SEG_WIDTH));
        assign ctl_d[k] = '{valid: stage_vin[k], carry: seg_cout[k], cmsb: seg_cmsb[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NSEG); k++) begin
                ctl_q[k] <= '0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < int'(NSEG); k++) begin
                ctl_q[k] <= ctl_d[k];
                sum_q[k] <= sum_d[k];
                a_q[k]   <= stage_a[k];
                b_q[k]   <= stage_b[k];
            end
        end
    end

    assign out_valid = ctl_q[NSEG-1].valid;
    assign sum       = sum_q[NSEG-1];
    assign cout      = ctl_q[NSEG-1].carry;
    assign ovf       = ctl_q[NSEG-1].carry ^ ctl_q[NSEG-1].cmsb;

endmodule
